// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: two read ports, one write port,
// clear request and status flags.
interface param_register_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) ();
  logic [ADDR_W-1:0] read1;
  logic [ADDR_W-1:0] read2;
  logic [DATA_W-1:0] read_out1;
  logic [DATA_W-1:0] read_out2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic              clear_req;
  logic              busy;
  logic              wr_drop;

  modport master (
    output read1, read2, write_reg, write_data, reg_write, clear_req,
    input  read_out1, read_out2, busy, wr_drop
  );

  modport slave (
    input  read1, read2, write_reg, write_data, reg_write, clear_req,
    output read_out1, read_out2, busy, wr_drop
  );
endinterface

// File: rtl/param_register_file.sv
// Parameterised register file with two combinational read ports, one write
// port with same-cycle bypass, and a sequential clear that walks every entry.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | zeroing entry clr_ptr each cycle; reads return 0, writes dropped
// IDLE  | normal operation; writes stored, reads bypass pending write
module param_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  param_register_file_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_drop_q;
  logic              wr_en;
  logic [DATA_W-1:0] rd1, rd2;

  // Writes only land in IDLE; entry 0 is never written when hardwired to zero.
  assign wr_en = (state == IDLE) && bus.reg_write &&
                 !(ZERO_REG && (bus.write_reg == '0));

  // State register, clear pointer and the registered write-drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_ptr   <= clr_ptr_nxt;
      wr_drop_q <= (state == CLEAR) && bus.reg_write;
    end
  end

  // Next state: CLEAR walks all entries once, IDLE waits for a clear request.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST_PTR) begin
          state_nxt   = IDLE;
          clr_ptr_nxt = '0;
        end
      end
      IDLE: begin
        if (bus.clear_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Storage: zeroed one entry per cycle during clear, otherwise written on request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_en) begin
        mem[bus.write_reg] <= bus.write_data;
      end
    end
  end

  // Read ports: forced to zero while clearing or for hardwired entry 0,
  // otherwise a pending write to the same address is forwarded.
  always_comb begin
    rd1 = mem[bus.read1];
    rd2 = mem[bus.read2];
    if (state == IDLE && bus.reg_write && bus.write_reg == bus.read1) rd1 = bus.write_data;
    if (state == IDLE && bus.reg_write && bus.write_reg == bus.read2) rd2 = bus.write_data;
    if (ZERO_REG && bus.read1 == '0) rd1 = '0;
    if (ZERO_REG && bus.read2 == '0) rd2 = '0;
    if (state == CLEAR) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

  assign bus.read_out1 = rd1;
  assign bus.read_out2 = rd2;
  assign bus.busy      = (state == CLEAR);
  assign bus.wr_drop   = wr_drop_q;
endmodule

// File: tb/tb_param_register_file.sv
// Directed bench: default config driven by a vector table, plus hand-written
// sequences for clear timing, dropped writes, hardwired zero and reset restart.
module tb_param_register_file;
  logic clk;
  logic rst0, rst1, rst2;
  int   total = 0;
  int   bad   = 0;

  param_register_file_if #(.DATA_W(16), .ADDR_W(2)) i0 ();
  param_register_file_if #(.DATA_W(16), .ADDR_W(2)) i1 ();
  param_register_file_if #(.DATA_W(32), .ADDR_W(3)) i2 ();

  param_register_file #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .bus(i0));
  param_register_file #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .reset(rst1), .bus(i1));
  param_register_file #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b0)) dut2 (
    .clk(clk), .reset(rst2), .bus(i2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic [1:0]  r1;
    logic [1:0]  r2;
    logic [15:0] e1;
    logic [15:0] e2;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int cnt;
    vecs[0] = '{1'b1, 2'd2, 16'hBEEF, 2'd2, 2'd2, 16'hBEEF, 16'hBEEF};
    vecs[1] = '{1'b0, 2'd0, 16'h0000, 2'd2, 2'd2, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b1, 2'd2, 16'h1234, 2'd2, 2'd0, 16'h1234, 16'h0000};
    vecs[3] = '{1'b0, 2'd0, 16'h0000, 2'd2, 2'd3, 16'h1234, 16'h0000};
    vecs[4] = '{1'b1, 2'd0, 16'hAAAA, 2'd0, 2'd1, 16'hAAAA, 16'h0000};
    vecs[5] = '{1'b1, 2'd1, 16'h5555, 2'd0, 2'd1, 16'hAAAA, 16'h5555};
    vecs[6] = '{1'b1, 2'd3, 16'h0F0F, 2'd3, 2'd2, 16'h0F0F, 16'h1234};
    vecs[7] = '{1'b0, 2'd0, 16'h0000, 2'd1, 2'd3, 16'h5555, 16'h0F0F};
    vecs[8] = '{1'b1, 2'd1, 16'h7777, 2'd2, 2'd1, 16'h1234, 16'h7777};
    vecs[9] = '{1'b0, 2'd0, 16'h0000, 2'd1, 2'd1, 16'h7777, 16'h7777};

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    {i0.read1, i0.read2, i0.write_reg, i0.write_data, i0.reg_write, i0.clear_req} = '0;
    {i1.read1, i1.read2, i1.write_reg, i1.write_data, i1.reg_write, i1.clear_req} = '0;
    {i2.read1, i2.read2, i2.write_reg, i2.write_data, i2.reg_write, i2.clear_req} = '0;

    // ---- dut0: reset and first clear ----
    step(); step();
    #2;
    chk("rst_busy", 32'(i0.busy), 32'd1);
    chk("rst_wr_drop", 32'(i0.wr_drop), 32'd0);
    chk("rst_read_out1", 32'(i0.read_out1), 32'd0);
    rst0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("init_busy_c%0d", k), 32'(i0.busy), 32'd1);
      step();
    end
    #2;
    chk("init_busy_end", 32'(i0.busy), 32'd0);
    for (int a = 0; a < 4; a += 2) begin
      i0.read1 = 2'(a); i0.read2 = 2'(a + 1);
      #2;
      chk($sformatf("init_zero_r%0d", a), 32'(i0.read_out1), 32'd0);
      chk($sformatf("init_zero_r%0d", a + 1), 32'(i0.read_out2), 32'd0);
      step();
    end

    // ---- dut0: table-driven IDLE traffic ----
    for (int v = 0; v < 10; v++) begin
      i0.reg_write = vecs[v].we; i0.write_reg = vecs[v].wa; i0.write_data = vecs[v].wd;
      i0.read1 = vecs[v].r1; i0.read2 = vecs[v].r2;
      #2;
      chk($sformatf("vec%0d_out1", v), 32'(i0.read_out1), 32'(vecs[v].e1));
      chk($sformatf("vec%0d_out2", v), 32'(i0.read_out2), 32'(vecs[v].e2));
      chk($sformatf("vec%0d_busy", v), 32'(i0.busy), 32'd0);
      step();
      #2;
      chk($sformatf("vec%0d_wr_drop", v), 32'(i0.wr_drop), 32'd0);
    end
    i0.reg_write = 1'b0;

    // ---- dut0: write during clear is dropped ----
    i0.clear_req = 1'b1; i0.read1 = 2'd2;
    step();
    i0.clear_req = 1'b0;
    #2;
    chk("clr_busy_c1", 32'(i0.busy), 32'd1);
    chk("clr_read_zero", 32'(i0.read_out1), 32'd0);
    step();
    i0.reg_write = 1'b1; i0.write_reg = 2'd0; i0.write_data = 16'hDEAD;
    #2;
    chk("drop_before", 32'(i0.wr_drop), 32'd0);
    step();
    i0.reg_write = 1'b0;
    #2;
    chk("drop_pulse", 32'(i0.wr_drop), 32'd1);
    chk("drop_busy", 32'(i0.busy), 32'd1);
    step();
    #2;
    chk("drop_one_cycle", 32'(i0.wr_drop), 32'd0);
    chk("clr_busy_c4", 32'(i0.busy), 32'd1);
    step();
    #2;
    chk("clr_busy_end", 32'(i0.busy), 32'd0);
    for (int a = 0; a < 4; a++) begin
      i0.read1 = 2'(a);
      #2;
      chk($sformatf("after_drop_r%0d", a), 32'(i0.read_out1), 32'd0);
      step();
    end

    // ---- dut0: fill, clear, re-request during clear ----
    for (int a = 0; a < 4; a++) begin
      i0.reg_write = 1'b1; i0.write_reg = 2'(a); i0.write_data = 16'(16'h1100 + a);
      step();
    end
    i0.reg_write = 1'b0;
    for (int a = 0; a < 4; a++) begin
      i0.read1 = 2'(a);
      #2;
      chk($sformatf("fill_r%0d", a), 32'(i0.read_out1), 32'(16'h1100 + a));
      step();
    end
    i0.clear_req = 1'b1;
    step();
    #2;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      i0.clear_req = (c == 0 || c == 2);
      #2;
      if (i0.busy) cnt++;
      step();
    end
    i0.clear_req = 1'b0;
    chk("reclear_busy_cycles", 32'(cnt), 32'd4);
    for (int a = 0; a < 4; a++) begin
      i0.read2 = 2'(a);
      #2;
      chk($sformatf("reclear_r%0d", a), 32'(i0.read_out2), 32'd0);
      step();
    end

    // ---- dut0: write and clear_req together ----
    i0.reg_write = 1'b1; i0.write_reg = 2'd1; i0.write_data = 16'h9999;
    i0.clear_req = 1'b1; i0.read1 = 2'd1;
    #2;
    chk("wr_clr_bypass", 32'(i0.read_out1), 32'h9999);
    step();
    i0.reg_write = 1'b0; i0.clear_req = 1'b0;
    repeat (4) step();
    #2;
    chk("wr_clr_zeroed", 32'(i0.read_out1), 32'd0);
    chk("wr_clr_wr_drop", 32'(i0.wr_drop), 32'd0);

    // ---- dut1: hardwired zero entry ----
    rst1 = 1'b0;
    repeat (4) step();
    i1.reg_write = 1'b1; i1.write_reg = 2'd0; i1.write_data = 16'hFFFF; i1.read1 = 2'd0;
    #2;
    chk("zr_bypass_zero", 32'(i1.read_out1), 32'd0);
    step();
    i1.write_reg = 2'd1; i1.write_data = 16'h1111; i1.read2 = 2'd1;
    #2;
    chk("zr_wr_drop", 32'(i1.wr_drop), 32'd0);
    chk("zr_after_zero", 32'(i1.read_out1), 32'd0);
    chk("zr_r1_bypass", 32'(i1.read_out2), 32'h1111);
    step();
    i1.reg_write = 1'b0;
    #2;
    chk("zr_r1_stored", 32'(i1.read_out2), 32'h1111);
    chk("zr_r0_stays", 32'(i1.read_out1), 32'd0);

    // ---- dut2: wide config, reset mid-clear ----
    rst2 = 1'b0;
    repeat (8) step();
    #2;
    chk("w_busy_end", 32'(i2.busy), 32'd0);
    i2.reg_write = 1'b1; i2.write_reg = 3'd7; i2.write_data = 32'hDEADBEEF;
    step();
    i2.write_reg = 3'd0; i2.write_data = 32'h12345678;
    step();
    i2.reg_write = 1'b0; i2.read1 = 3'd7; i2.read2 = 3'd0;
    #2;
    chk("w_r7_stored", i2.read_out1, 32'hDEADBEEF);
    chk("w_r0_stored", i2.read_out2, 32'h12345678);
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    repeat (5) step();
    #2;
    chk("w_mid_busy", 32'(i2.busy), 32'd1);
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    #2;
    chk("w_rst_wr_drop", 32'(i2.wr_drop), 32'd0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (i2.busy) cnt++;
      step();
    end
    chk("w_restart_cycles", 32'(cnt), 32'd8);
    #2;
    chk("w_r7_zero", i2.read_out1, 32'd0);
    chk("w_r0_zero", i2.read_out2, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/param_register_file.md
PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter DATA_W, 16, width of each register entry in bits.
REQ-002 Parameter ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, 0, when 1 entry 0 is hardwired to zero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 read1, read2  input  ADDR_W each  read port addresses.
REQ-007 read_out1, read_out2  output  DATA_W each  combinational read data.
REQ-008 write_reg  input  ADDR_W  write address.
REQ-009 write_data  input  DATA_W  write data.
REQ-010 reg_write  input  1  write request, sampled at rising edge.
REQ-011 clear_req  input  1  request a full clear of all entries.
REQ-012 busy  output  1  high while a clear sequence is in progress.
REQ-013 wr_drop  output  1  registered one-cycle pulse: a write was discarded.

Function
REQ-014 The FSM SHALL have two states: CLEAR and IDLE.
REQ-015 CLEAR SHALL zero entry clr_ptr each cycle, then increment clr_ptr (ADDR_W bits).
REQ-016 CLEAR SHALL go to IDLE in the cycle it zeroes entry DEPTH-1; a clear takes exactly DEPTH cycles.
REQ-017 In IDLE, clear_req=1 SHALL go to CLEAR with clr_ptr=0 on the next edge.
REQ-018 clear_req asserted during CLEAR SHALL be ignored; it neither restarts nor extends the sequence.
REQ-019 busy SHALL equal 1 exactly when the state is CLEAR.
REQ-020 In IDLE, reg_write=1 SHALL store write_data at write_reg on the rising edge.
REQ-021 With ZERO_REG=1, writes to entry 0 SHALL be discarded silently; wr_drop stays 0.
REQ-022 reg_write=1 while busy=1 SHALL be discarded, and wr_drop SHALL be 1 in the following cycle.
REQ-023 reg_write=1 with clear_req=1 in the same IDLE cycle SHALL complete the write; the clear then zeroes it.
REQ-024 While busy=1, read_out1 and read_out2 SHALL both be 0.
REQ-025 In IDLE, read_outN SHALL equal entry[readN], except under the bypass condition.
REQ-026 Bypass: when reg_write=1, IDLE, and write_reg==readN, read_outN SHALL equal write_data in the same cycle.
REQ-027 With ZERO_REG=1, readN==0 SHALL return 0 even under the bypass condition.
REQ-028 Both read ports SHALL be independent; equal addresses on both return identical data.
REQ-029 Storage SHALL NOT be written by anything other than REQ-015 and REQ-020.

Reset
REQ-030 While reset=1, state SHALL be CLEAR, clr_ptr=0, busy=1, wr_drop=0.
REQ-031 On the first edge with reset=0, the clear sequence SHALL run per REQ-015..016, zeroing all DEPTH entries including DEPTH-1.
REQ-032 Reset asserted mid-clear or mid-operation SHALL restart the clear from clr_ptr=0 on the next edge.
REQ-033 The block SHALL tolerate unknown storage contents at power-up; no read before busy falls is defined.

Verification
REQ-034 Cover: deassert reset with defaults -> busy high 4 cycles, then 0; read ports 0..3 all return 0x0000.
REQ-035 Cover: write 0xBEEF to reg 2, then read1=2, read2=2 -> both 0xBEEF; same-cycle read1=2 during write 0x1234 -> 0x1234.
REQ-036 Cover: reg_write during busy (cycle 2 of clear) -> entry unchanged, wr_drop=1 for exactly one cycle.
REQ-037 Cover: ZERO_REG=1, write 0xFFFF to reg 0 with read1=0 -> read_out1=0 that cycle and afterwards, wr_drop=0.
REQ-038 Cover: fill all regs, pulse clear_req, repulse at clear cycle 1 -> busy exactly DEPTH cycles, all entries 0.
REQ-039 Cover: DATA_W=32, ADDR_W=3, reset mid-clear at clr_ptr=5 -> 8-cycle clear restarts at 0, entry 7 reads 0.
